// File: rtl/glitch_count_monitor_if.sv
// Sample/control bundle between the delay-line ones-counter side and the glitch monitor.
// The master drives the samples and controls. The slave (the monitor) returns the status.
interface glitch_count_monitor_if #(
    parameter int CNT_W = 7,
    parameter int EVT_W = 16
);
    logic             enable;
    logic             recal;
    logic             clear_alarm;
    logic [CNT_W-1:0] count_in;
    logic             count_vld;
    logic [CNT_W-1:0] baseline;
    logic             baseline_vld;
    logic             glitch_pulse;
    logic             in_alarm;
    logic             alarm_sticky;
    logic [EVT_W-1:0] event_cnt;
    logic [CNT_W-1:0] min_seen;
    logic [CNT_W-1:0] max_seen;
    logic [1:0]       state;

    modport master (
        output enable, recal, clear_alarm, count_in, count_vld,
        input  baseline, baseline_vld, glitch_pulse, in_alarm, alarm_sticky,
               event_cnt, min_seen, max_seen, state
    );

    modport slave (
        input  enable, recal, clear_alarm, count_in, count_vld,
        output baseline, baseline_vld, glitch_pulse, in_alarm, alarm_sticky,
               event_cnt, min_seen, max_seen, state
    );
endinterface

// File: rtl/glitch_count_monitor.sv
// Voltage-glitch decision logic: learns a baseline ones-count and then flags samples
// whose absolute deviation from that baseline exceeds THRESH. It also tracks alarm hold, events and excursions.
module glitch_count_monitor #(
    parameter int CNT_W       = 7,
    parameter int CAL_LOG2    = 6,
    parameter int THRESH      = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int EVT_W       = 16
) (
    input logic                   clk,
    input logic                   rst,
    glitch_count_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALIB = 2'd1,
        ARMED = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam int ACC_W  = CNT_W + CAL_LOG2;
    localparam int HOLD_W = 16;
    localparam logic [CNT_W:0]    THRESH_V = (CNT_W + 1)'(THRESH);
    localparam logic [HOLD_W-1:0] HOLD_V   = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_t              state_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CAL_LOG2-1:0] sample_cnt_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [CNT_W-1:0]    baseline_q;
    logic [CNT_W-1:0]    min_q;
    logic [CNT_W-1:0]    max_q;
    logic                baseline_vld_q;
    logic                pulse_q;
    logic                in_alarm_q;
    logic                sticky_q;
    logic [EVT_W-1:0]    event_q;

    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W:0]   deviation;
    logic             monitoring;
    logic             violation;
    logic [CNT_W-1:0] min_base;
    logic [CNT_W-1:0] max_base;
    logic [CNT_W-1:0] min_next;
    logic [CNT_W-1:0] max_next;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        acc_sum    = acc_q + ACC_W'(mon.count_in);
        monitoring = mon.enable && !mon.recal && mon.count_vld
                     && (state_q == ARMED || state_q == ALARM);
        if (mon.count_in >= baseline_q) deviation = {1'b0, mon.count_in} - {1'b0, baseline_q};
        else                            deviation = {1'b0, baseline_q} - {1'b0, mon.count_in};
        violation = monitoring && (deviation > THRESH_V);
        // A sample monitored on the same edge as a clear restarts the capture from that sample.
        min_base = mon.clear_alarm ? '1 : min_q;
        max_base = mon.clear_alarm ? '0 : max_q;
        min_next = min_base;
        max_next = max_base;
        if (monitoring && mon.count_in < min_base) min_next = mon.count_in;
        if (monitoring && mon.count_in > max_base) max_next = mon.count_in;
    end

    // NOTE: sequential state uses non-blocking assignments only, so register updates never race.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            sample_cnt_q   <= '0;
            hold_q         <= '0;
            baseline_q     <= '0;
            baseline_vld_q <= 1'b0;
            pulse_q        <= 1'b0;
            in_alarm_q     <= 1'b0;
            sticky_q       <= 1'b0;
            event_q        <= '0;
            min_q          <= '1;
            max_q          <= '0;
        end else begin
            pulse_q <= 1'b0;
            min_q   <= min_next;
            max_q   <= max_next;
            if (violation)             sticky_q <= 1'b1;
            else if (mon.clear_alarm)  sticky_q <= 1'b0;

            if (!mon.enable) begin
                state_q        <= IDLE;
                baseline_vld_q <= 1'b0;
                in_alarm_q     <= 1'b0;
            end else if (mon.recal && state_q != IDLE) begin
                state_q        <= CALIB;
                acc_q          <= '0;
                sample_cnt_q   <= '0;
                baseline_vld_q <= 1'b0;
                in_alarm_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q      <= CALIB;
                        acc_q        <= '0;
                        sample_cnt_q <= '0;
                    end
                    CALIB: if (mon.count_vld) begin
                        acc_q        <= acc_sum;
                        sample_cnt_q <= sample_cnt_q + 1'b1;
                        if (&sample_cnt_q) begin
                            baseline_q     <= CNT_W'(acc_sum >> CAL_LOG2);
                            baseline_vld_q <= 1'b1;
                            state_q        <= ARMED;
                        end
                    end
                    ARMED: if (violation) begin
                        pulse_q    <= 1'b1;
                        hold_q     <= HOLD_V;
                        in_alarm_q <= 1'b1;
                        state_q    <= ALARM;
                        if (~&event_q) event_q <= event_q + 1'b1;
                    end
                    ALARM: begin
                        if (violation) begin
                            pulse_q <= 1'b1;
                            hold_q  <= HOLD_V;
                        end else if (hold_q == HOLD_ONE) begin
                            hold_q     <= '0;
                            in_alarm_q <= 1'b0;
                            state_q    <= ARMED;
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mon.baseline     = baseline_q;
    assign mon.baseline_vld = baseline_vld_q;
    assign mon.glitch_pulse = pulse_q;
    assign mon.in_alarm     = in_alarm_q;
    assign mon.alarm_sticky = sticky_q;
    assign mon.event_cnt    = event_q;
    assign mon.min_seen     = min_q;
    assign mon.max_seen     = max_q;
    assign mon.state        = state_q;
endmodule
